// File: rtl/col_sense_ctrl_pkg.sv
// Shared SRAM column definitions: read-sequencer state encoding, the default
// word width common with the write driver, and the counter sizing helper.
package col_sense_ctrl_pkg;

  localparam int unsigned SRAM_WIDTH = 32'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DEV   = 3'd2,
    ST_SENSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Phase counter width: enough for max(pre, dev) - 1, never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/col_sense_ctrl_chk.sv
// Protocol invariants of the column read sequencer: precharge and wordline are
// exclusive, the sense amp only fires under an open wordline, valid is a pulse.
module col_sense_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic pre_en,
  input logic wl_en,
  input logic sa_en,
  input logic rd_valid,
  input logic sense_err
);

  a_pre_wl_excl: assert property (@(posedge clk) disable iff (!rst_n) !(pre_en && wl_en));

  a_sa_needs_wl: assert property (@(posedge clk) disable iff (!rst_n) sa_en |-> wl_en);

  a_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n) rd_valid |=> !rd_valid);

  a_err_with_valid: assert property (@(posedge clk) disable iff (!rst_n) sense_err |-> rd_valid);

endmodule

// File: rtl/col_sense_resolve.sv
// Per-column differential resolver: a clean (1,0) or (0,1) BL/BLB pair gives
// the data bit; any other combination reads as 0 and raises that column's error.
module col_sense_resolve
  import col_sense_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SRAM_WIDTH
) (
  input  logic [WIDTH-1:0] bl,
  input  logic [WIDTH-1:0] blb,
  output logic [WIDTH-1:0] res_bit,
  output logic [WIDTH-1:0] res_err
);

  // Casez-free match so X/Z pairs fall through to the error branch in simulation.
  always_comb begin
    res_bit = '0;
    res_err = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({bl[i], blb[i]})
        2'b10: begin
          res_bit[i] = 1'b1;
          res_err[i] = 1'b0;
        end
        2'b01: begin
          res_bit[i] = 1'b0;
          res_err[i] = 1'b0;
        end
        default: begin
          res_bit[i] = 1'b0;
          res_err[i] = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/col_sense_ctrl.sv
// SRAM column read sequencer: precharge, wordline development, sense-amp fire,
// then capture of the resolved BL/BLB word into a registered output.
module col_sense_ctrl
  import col_sense_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = SRAM_WIDTH,
  parameter int unsigned PRE_CYCLES = 32'd2,
  parameter int unsigned DEV_CYCLES = 32'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             r_en,
  input  logic [WIDTH-1:0] BL,
  input  logic [WIDTH-1:0] BLB,
  output logic             pre_en,
  output logic             wl_en,
  output logic             sa_en,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             sense_err,
  output logic             busy
);

  localparam int unsigned    CW       = cnt_width(PRE_CYCLES, DEV_CYCLES);
  localparam logic [CW-1:0]  PRE_LOAD = CW'(PRE_CYCLES - 32'd1);
  localparam logic [CW-1:0]  DEV_LOAD = CW'(DEV_CYCLES - 32'd1);

  state_e            state_r;
  state_e            next_state_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_next_s;
  logic [WIDTH-1:0]  res_bit_s;
  logic [WIDTH-1:0]  res_err_s;

  logic              pre_s;
  logic              wl_s;
  logic              sa_s;
  logic              vld_s;
  logic              err_s;
  logic              busy_s;
  logic [WIDTH-1:0]  dout_s;

  col_sense_resolve #(.WIDTH(WIDTH)) u_resolve (
    .bl      (BL),
    .blb     (BLB),
    .res_bit (res_bit_s),
    .res_err (res_err_s)
  );

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic; cs low anywhere in the sequence aborts back to IDLE.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (cs && r_en) begin
          next_state_s = ST_PRE;
          cnt_next_s   = PRE_LOAD;
        end else begin
          next_state_s = ST_IDLE;
          cnt_next_s   = '0;
        end
      end
      ST_PRE: begin
        if (!cs) begin
          next_state_s = ST_IDLE;
          cnt_next_s   = '0;
        end else if (cnt_r == '0) begin
          next_state_s = ST_DEV;
          cnt_next_s   = DEV_LOAD;
        end else begin
          next_state_s = ST_PRE;
          cnt_next_s   = cnt_r - CW'(1);
        end
      end
      ST_DEV: begin
        if (!cs) begin
          next_state_s = ST_IDLE;
          cnt_next_s   = '0;
        end else if (cnt_r == '0) begin
          next_state_s = ST_SENSE;
          cnt_next_s   = '0;
        end else begin
          next_state_s = ST_DEV;
          cnt_next_s   = cnt_r - CW'(1);
        end
      end
      ST_SENSE: begin
        if (!cs) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
        cnt_next_s = '0;
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = '0;
      end
      default: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output lands in a register.
  always_comb begin
    pre_s  = 1'b0;
    wl_s   = 1'b0;
    sa_s   = 1'b0;
    vld_s  = 1'b0;
    err_s  = 1'b0;
    busy_s = 1'b0;
    dout_s = dout;
    case (next_state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_PRE: begin
        pre_s  = 1'b1;
        busy_s = 1'b1;
      end
      ST_DEV: begin
        wl_s   = 1'b1;
        busy_s = 1'b1;
      end
      ST_SENSE: begin
        wl_s   = 1'b1;
        sa_s   = 1'b1;
        busy_s = 1'b1;
      end
      ST_DONE: begin
        vld_s  = 1'b1;
        err_s  = |res_err_s;
        busy_s = 1'b1;
        dout_s = res_bit_s;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_en    <= 1'b0;
      wl_en     <= 1'b0;
      sa_en     <= 1'b0;
      rd_valid  <= 1'b0;
      sense_err <= 1'b0;
      busy      <= 1'b0;
      dout      <= '0;
    end else begin
      pre_en    <= pre_s;
      wl_en     <= wl_s;
      sa_en     <= sa_s;
      rd_valid  <= vld_s;
      sense_err <= err_s;
      busy      <= busy_s;
      dout      <= dout_s;
    end
  end

endmodule

// File: tb/tb_col_sense_ctrl.sv
// Self-checking bench for col_sense_ctrl: vector table, hand sequences for
// back-to-back, abort and async reset, then random traffic against a model.
module tb_col_sense_ctrl;

  localparam int W   = 8;
  localparam int PRE = 2;
  localparam int DEV = 3;
  localparam int L   = PRE + DEV + 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs    = 1'b0;
  logic         r_en  = 1'b0;
  logic [W-1:0] BL    = '0;
  logic [W-1:0] BLB   = '0;
  logic         pre_en, wl_en, sa_en, rd_valid, sense_err, busy;
  logic [W-1:0] dout;

  always #5 clk = ~clk;

  col_sense_ctrl #(.WIDTH(W), .PRE_CYCLES(PRE), .DEV_CYCLES(DEV)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .r_en(r_en), .BL(BL), .BLB(BLB),
    .pre_en(pre_en), .wl_en(wl_en), .sa_en(sa_en), .dout(dout),
    .rd_valid(rd_valid), .sense_err(sense_err), .busy(busy)
  );

  col_sense_ctrl_chk chk (
    .clk(clk), .rst_n(rst_n), .pre_en(pre_en), .wl_en(wl_en), .sa_en(sa_en),
    .rd_valid(rd_valid), .sense_err(sense_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: a read is "age" edges old; outputs follow from where age falls in the timeline.
  int           age    = 0;
  logic [W-1:0] m_dout = '0;
  logic         m_err  = 1'b0;

  function automatic logic [W:0] resolve(input logic [W-1:0] bl, input logic [W-1:0] blb);
    logic [W:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (bl[i] === 1'b1 && blb[i] === 1'b0) r[i] = 1'b1;
      else if (bl[i] === 1'b0 && blb[i] === 1'b1) r[i] = 1'b0;
      else r[W] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [W:0] r;
    int nxt;
    if (!rst_n) begin
      age    <= 0;
      m_dout <= '0;
      m_err  <= 1'b0;
    end else begin
      if (age == 0) nxt = (cs && r_en) ? 1 : 0;
      else if (!cs || age == L) nxt = 0;
      else nxt = age + 1;
      if (nxt == L) begin
        r = resolve(BL, BLB);
        m_dout <= r[W-1:0];
        m_err  <= r[W];
      end
      age <= nxt;
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("model", 32'({pre_en, wl_en, sa_en, rd_valid, sense_err, busy, dout}),
            32'({(age >= 1 && age <= PRE), (age > PRE && age <= PRE + DEV + 1),
                 (age == PRE + DEV + 1), (age == L), (age == L) && m_err,
                 (age != 0), m_dout}));
    end
  end

  task automatic do_read(input logic [W-1:0] bl, input logic [W-1:0] blb,
                         output int lat, output logic [W-1:0] d, output logic e);
    @(negedge clk);
    BL = bl; BLB = blb; cs = 1'b1; r_en = 1'b1;
    lat = -1; d = '0; e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      r_en = 1'b0;
      check("phase", 32'({pre_en, wl_en, sa_en}),
            32'({(n <= PRE), (n > PRE && n <= PRE + DEV + 1), (n == PRE + DEV + 1)}));
      if (rd_valid) begin
        lat = n; d = dout; e = sense_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] bl;
    logic [W-1:0] blb;
    logic [W-1:0] dout;
    logic         err;
  } vec_t;

  vec_t vt [6];

  initial begin
    int           lat;
    logic [W-1:0] d;
    logic         e;
    int           t [3];
    logic [W-1:0] dv [3];
    logic [W-1:0] seq [3];
    int           k;
    int           seen;

    vt[0] = '{8'hA5, 8'h5A, 8'hA5, 1'b0};
    vt[1] = '{8'hFF, 8'h7F, 8'h80, 1'b1};
    vt[2] = '{8'h01, 8'hFE, 8'h01, 1'b0};
    vt[3] = '{8'h00, 8'h00, 8'h00, 1'b1};
    vt[4] = '{8'h3C, 8'hC3, 8'h3C, 1'b0};
    vt[5] = '{8'h0F, 8'hFF, 8'h00, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({pre_en, wl_en, sa_en, rd_valid, sense_err, busy, dout}), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single reads from the table
    for (int i = 0; i < 6; i++) begin
      do_read(vt[i].bl, vt[i].blb, lat, d, e);
      check("latency", 32'(lat), 32'(L));
      check("dout", 32'(d), 32'(vt[i].dout));
      check("sense_err", 32'(e), 32'(vt[i].err));
      @(negedge clk);
      check("busy_after", 32'({busy, rd_valid}), 32'd0);
    end

    // Back-to-back reads with r_en held high
    seq[0] = 8'h01; seq[1] = 8'hFE; seq[2] = 8'h3C;
    @(negedge clk);
    BL = seq[0]; BLB = ~seq[0]; cs = 1'b1; r_en = 1'b1;
    k = 0;
    for (int n = 0; n < 40 && k < 3; n++) begin
      @(negedge clk);
      if (rd_valid) begin
        t[k] = cyc; dv[k] = dout; k++;
        if (k < 3) begin BL = seq[k]; BLB = ~seq[k]; end
        else r_en = 1'b0;
      end
    end
    check("b2b_count", 32'(k), 32'd3);
    if (k == 3) begin
      check("b2b_gap1", 32'(t[1] - t[0]), 32'(PRE + DEV + 3));
      check("b2b_gap2", 32'(t[2] - t[1]), 32'(PRE + DEV + 3));
      for (int i = 0; i < 3; i++) check("b2b_dout", 32'(dv[i]), 32'(seq[i]));
    end
    repeat (2) @(negedge clk);

    // Abort with cs dropped during DEV
    @(negedge clk);
    BL = 8'hAA; BLB = 8'h55; cs = 1'b1; r_en = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      r_en = 1'b0;
      if (n == 4) cs = 1'b0;
    end
    @(negedge clk);
    check("abort_idle", 32'({pre_en, wl_en, sa_en, rd_valid, busy}), 32'd0);
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rd_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_dout_held", 32'(dout), 32'h3C);

    // Asynchronous reset in the middle of PRE
    @(negedge clk);
    BL = 8'h11; BLB = 8'hEE; cs = 1'b1; r_en = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0; r_en = 1'b0;
    #1;
    check("async_rst", 32'({pre_en, wl_en, sa_en, rd_valid, sense_err, busy, dout}), 32'd0);
    #1;
    rst_n = 1'b1;
    do_read(8'hA5, 8'h5A, lat, d, e);
    check("post_rst_latency", 32'(lat), 32'(L));
    check("post_rst_dout", 32'({e, d}), 32'h0A5);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cs   = ($urandom_range(0, 15) != 0);
      r_en = ($urandom_range(0, 3) != 0);
      BL   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) BLB = ~BL ^ (8'h01 << $urandom_range(0, 7));
      else BLB = ~BL;
    end
    cs = 1'b0; r_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
